// File: rtl/commit_trace_if.sv
// Commit trace port bundle: core-side event inputs, readout request and the
// captured-history / status outputs of the trace buffer.
interface commit_trace_if #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    commit_valid;
  logic [31:0]             commit_pc;
  logic                    mispredict;
  logic [31:0]             mispredict_pc;
  logic                    trig_en;
  logic [31:0]             trig_pc;
  logic                    clear;
  logic                    rd_req;
  logic                    rd_valid;
  logic [2+32+STAMP_W-1:0] rd_data;
  logic                    rd_last;
  logic                    frozen;
  logic                    hang;
  logic [15:0]             mispredict_count;
  logic [CW-1:0]           entry_count;

  modport master (
    output commit_valid, commit_pc, mispredict, mispredict_pc,
    output trig_en, trig_pc, clear, rd_req,
    input  rd_valid, rd_data, rd_last, frozen, hang, mispredict_count, entry_count
  );

  modport slave (
    input  commit_valid, commit_pc, mispredict, mispredict_pc,
    input  trig_en, trig_pc, clear, rd_req,
    output rd_valid, rd_data, rd_last, frozen, hang, mispredict_count, entry_count
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular commit/mispredict/trigger/hang trace that freezes on a PC trigger
// (after a post-trigger window) or on a no-commit watchdog, then reads out oldest-first.
module commit_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int STAMP_W     = 16,
  parameter int POST_TRIG   = 4,
  parameter int HANG_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  commit_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(HANG_CYCLES);
  localparam int EW = 2 + 32 + STAMP_W;

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [IW-1:0] IDLE_FIRE = IW'(HANG_CYCLES - 2);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  localparam logic [1:0] T_COMMIT  = 2'b00;
  localparam logic [1:0] T_MISPRED = 2'b01;
  localparam logic [1:0] T_HANG    = 2'b10;
  localparam logic [1:0] T_TRIG    = 2'b11;

  typedef enum logic [1:0] {RUN, POST, FROZEN} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] v);
    return (v == FULL) ? v : v + CW'(1);
  endfunction

  state_t               state;
  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_idx;
  logic [AW-1:0]        post_cnt;
  logic [CW-1:0]        count;
  logic [STAMP_W-1:0]   stamp;
  logic [IW-1:0]        idle_cnt;
  logic [15:0]          mp_count;
  logic                 hang_q;
  logic                 frozen_q;
  logic                 rd_valid_q;
  logic                 rd_last_q;
  logic [EW-1:0]        rd_data_q;

  logic                 active;
  logic                 hang_ev;
  logic                 trig_ev;
  logic                 log_en;
  logic [1:0]           log_type;
  logic [31:0]          log_pc;
  logic [AW-1:0]        oldest;
  logic [AW-1:0]        rd_addr;
  logic [CW-1:0]        count_m1;
  logic                 at_last;

  // Event decode: at most one entry per cycle, HANG > MISPREDICT > TRIGGER > COMMIT.
  always_comb begin
    active   = (state != FROZEN);
    hang_ev  = active && !bus.commit_valid && (idle_cnt == IDLE_FIRE);
    trig_ev  = (state == RUN) && bus.commit_valid && bus.trig_en &&
               (bus.commit_pc == bus.trig_pc) && !bus.mispredict;
    log_en   = active && (hang_ev || bus.mispredict || bus.commit_valid);
    log_type = T_COMMIT;
    log_pc   = bus.commit_pc;
    if (hang_ev) begin
      log_type = T_HANG;
      log_pc   = '0;
    end else if (bus.mispredict) begin
      log_type = T_MISPRED;
      log_pc   = bus.mispredict_pc;
    end else if (trig_ev) begin
      log_type = T_TRIG;
    end
    // Oldest slot is wr_ptr when full (low bits of DEPTH are zero), else slot 0.
    oldest   = wr_ptr - count[AW-1:0];
    rd_addr  = oldest + rd_idx;
    count_m1 = count - CW'(1);
    at_last  = (rd_idx == count_m1[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      post_cnt   <= '0;
      count      <= '0;
      stamp      <= '0;
      idle_cnt   <= '0;
      mp_count   <= '0;
      hang_q     <= 1'b0;
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      stamp      <= stamp + STAMP_W'(1);
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      if (active) begin
        if (log_en) begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= sat_count(count);
        end
        if (bus.mispredict) mp_count <= sat_inc16(mp_count);
        idle_cnt <= bus.commit_valid ? '0 : idle_cnt + IW'(1);
        if (hang_ev) begin
          state    <= FROZEN;
          frozen_q <= 1'b1;
          hang_q   <= 1'b1;
        end else if (trig_ev) begin
          if (POST_TRIG == 0) begin
            state    <= FROZEN;
            frozen_q <= 1'b1;
          end else begin
            state    <= POST;
            post_cnt <= POST_INIT;
          end
        end else if (state == POST && log_en) begin
          post_cnt <= post_cnt - AW'(1);
          if (post_cnt == AW'(1)) begin
            state    <= FROZEN;
            frozen_q <= 1'b1;
          end
        end
      end else if (bus.rd_req && count != '0) begin
        // Non-destructive readout: wrap back to the oldest entry after the newest.
        rd_valid_q <= 1'b1;
        rd_data_q  <= mem[rd_addr];
        rd_last_q  <= at_last;
        rd_idx     <= at_last ? '0 : rd_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !bus.clear && log_en) mem[wr_ptr] <= {log_type, log_pc, stamp};
  end

  assign bus.rd_valid         = rd_valid_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.rd_last          = rd_last_q;
  assign bus.frozen           = frozen_q;
  assign bus.hang             = hang_q;
  assign bus.mispredict_count = mp_count;
  assign bus.entry_count      = count;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: two instances (POST_TRIG 4 and 0, HANG_CYCLES 8)
// share one stimulus stream; expected values are hand-computed tables and constants.
module tb_commit_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  commit_trace_if #(.DEPTH(16), .STAMP_W(16)) ifa ();
  commit_trace_if #(.DEPTH(16), .STAMP_W(16)) ifb ();

  commit_trace_buffer #(.DEPTH(16), .STAMP_W(16), .POST_TRIG(4), .HANG_CYCLES(8))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  commit_trace_buffer #(.DEPTH(16), .STAMP_W(16), .POST_TRIG(0), .HANG_CYCLES(8))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  assign ifb.commit_valid  = ifa.commit_valid;
  assign ifb.commit_pc     = ifa.commit_pc;
  assign ifb.mispredict    = ifa.mispredict;
  assign ifb.mispredict_pc = ifa.mispredict_pc;
  assign ifb.trig_en       = ifa.trig_en;
  assign ifb.trig_pc       = ifa.trig_pc;
  assign ifb.clear         = ifa.clear;
  assign ifb.rd_req        = ifa.rd_req;

  typedef struct {
    logic        cv;
    logic [31:0] pc;
    logic        mp;
    logic [31:0] mpc;
    logic [4:0]  exp_cnt;
    logic        exp_frz;
    logic [15:0] exp_mc;
  } vec_t;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] pc;
  } rd_t;

  vec_t vt [8];
  rd_t  rt [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [31:0] pc, input logic mp,
                       input logic [31:0] mpc, input logic te, input logic [31:0] tpc,
                       input logic clr, input logic rq);
    ifa.commit_valid  = cv;
    ifa.commit_pc     = pc;
    ifa.mispredict    = mp;
    ifa.mispredict_pc = mpc;
    ifa.trig_en       = te;
    ifa.trig_pc       = tpc;
    ifa.clear         = clr;
    ifa.rd_req        = rq;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic status(input bit sel, input string nm, input logic [4:0] cnt,
                        input logic frz, input logic hng, input logic [15:0] mc);
    check({nm, "_count"},  64'(sel ? ifb.entry_count      : ifa.entry_count),      64'(cnt));
    check({nm, "_frozen"}, 64'(sel ? ifb.frozen           : ifa.frozen),           64'(frz));
    check({nm, "_hang"},   64'(sel ? ifb.hang             : ifa.hang),             64'(hng));
    check({nm, "_mpcnt"},  64'(sel ? ifb.mispredict_count : ifa.mispredict_count), 64'(mc));
  endtask

  task automatic rd_check(input bit sel, input string nm, input logic [1:0] t,
                          input logic [31:0] pc, input logic [15:0] st, input logic last);
    logic        v;
    logic        l;
    logic [49:0] d;
    tick();
    v = sel ? ifb.rd_valid : ifa.rd_valid;
    l = sel ? ifb.rd_last  : ifa.rd_last;
    d = sel ? ifb.rd_data  : ifa.rd_data;
    check({nm, "_valid"}, 64'(v), 64'd1);
    check({nm, "_type"},  64'(d[49:48]), 64'(t));
    check({nm, "_pc"},    64'(d[47:16]), 64'(pc));
    check({nm, "_stamp"}, 64'(d[15:0]), 64'(st));
    check({nm, "_last"},  64'(l), 64'(last));
  endtask

  initial begin
    vt[0] = '{1'b1, 32'h30, 1'b0, 32'h0,  5'd1, 1'b0, 16'd0};
    vt[1] = '{1'b1, 32'h34, 1'b0, 32'h0,  5'd2, 1'b0, 16'd0};
    vt[2] = '{1'b1, 32'h40, 1'b0, 32'h0,  5'd3, 1'b0, 16'd0};
    vt[3] = '{1'b1, 32'h44, 1'b0, 32'h0,  5'd4, 1'b0, 16'd0};
    vt[4] = '{1'b1, 32'h48, 1'b0, 32'h0,  5'd5, 1'b0, 16'd0};
    vt[5] = '{1'b1, 32'h4C, 1'b0, 32'h0,  5'd6, 1'b0, 16'd0};
    vt[6] = '{1'b1, 32'h50, 1'b0, 32'h0,  5'd7, 1'b1, 16'd0};
    vt[7] = '{1'b1, 32'h54, 1'b1, 32'h60, 5'd7, 1'b1, 16'd0};
    rt[0] = '{2'b00, 32'h30};
    rt[1] = '{2'b00, 32'h34};
    rt[2] = '{2'b11, 32'h40};
    rt[3] = '{2'b00, 32'h44};
    rt[4] = '{2'b00, 32'h48};
    rt[5] = '{2'b00, 32'h4C};
    rt[6] = '{2'b00, 32'h50};

    // Power-up reset state
    do_reset();
    status(0, "rst", 5'd0, 1'b0, 1'b0, 16'd0);
    check("rst_rd_valid", 64'(ifa.rd_valid), 64'd0);

    // Trigger at 0x40 with four post-trigger commits, then oldest-first readout
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].cv, vt[i].pc, vt[i].mp, vt[i].mpc, 1'b1, 32'h40, 1'b0, 1'b0);
      tick();
      check($sformatf("trig_cnt%0d", i), 64'(ifa.entry_count), 64'(vt[i].exp_cnt));
      check($sformatf("trig_frz%0d", i), 64'(ifa.frozen), 64'(vt[i].exp_frz));
      check($sformatf("trig_mpc%0d", i), 64'(ifa.mispredict_count), 64'(vt[i].exp_mc));
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++)
      rd_check(0, $sformatf("trig_rd%0d", i), rt[i].t, rt[i].pc, 16'(i), logic'(i == 6));
    rd_check(0, "trig_rewrap", 2'b00, 32'h30, 16'd0, 1'b0);
    idle();
    tick();
    check("trig_rd_idle", 64'(ifa.rd_valid), 64'd0);

    // 20 commits then trigger with POST_TRIG=0: buffer wraps, readout starts at 6th entry
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(32'h1000 + 4 * i), 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h2000, 1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, 1'b0);
    tick();
    check("wrap_count",  64'(ifb.entry_count), 64'd16);
    check("wrap_frozen", 64'(ifb.frozen), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int j = 0; j < 16; j++)
      rd_check(1, $sformatf("wrap_rd%0d", j), (j == 15) ? 2'b11 : 2'b00,
               (j == 15) ? 32'h2000 : 32'(32'h1000 + 4 * (5 + j)), 16'(5 + j), logic'(j == 15));
    rd_check(1, "wrap_rewrap", 2'b00, 32'h1014, 16'd5, 1'b0);

    // Commit and mispredict in the same cycle, then watchdog freeze
    do_reset();
    drive(1'b1, 32'h80, 1'b1, 32'h7C, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    status(0, "mp", 5'd1, 1'b0, 1'b0, 16'd1);
    idle();
    repeat (7) tick();
    status(0, "mp_hang", 5'd2, 1'b1, 1'b1, 16'd1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    rd_check(0, "mp_rd0", 2'b01, 32'h7C, 16'd0, 1'b0);
    rd_check(0, "mp_rd1", 2'b10, 32'h0,  16'd7, 1'b1);

    // Watchdog boundary: frozen after exactly 7 idle cycles, late commit ignored, clear rearms
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    repeat (6) tick();
    status(0, "wd6", 5'd1, 1'b0, 1'b0, 16'd0);
    tick();
    status(0, "wd7", 5'd2, 1'b1, 1'b1, 16'd0);
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("wd_late_commit", 64'(ifa.entry_count), 64'd2);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    rd_check(0, "wd_rd0", 2'b00, 32'h100, 16'd0, 1'b0);
    rd_check(0, "wd_rd1", 2'b10, 32'h0,   16'd7, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    status(0, "wd_clear", 5'd0, 1'b0, 1'b0, 16'd0);
    check("wd_clear_rdv", 64'(ifa.rd_valid), 64'd0);

    // Reset mid-run with five entries logged; rd_req ignored while running
    do_reset();
    drive(1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h204, 1'b1, 32'h1F0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h208, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0,   1'b1, 32'h1F8, 1'b0, 32'h0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h20C, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1); tick();
    status(0, "mid", 5'd5, 1'b0, 1'b0, 16'd2);
    check("mid_rd_ignored", 64'(ifa.rd_valid), 64'd0);
    idle();
    reset = 1'b1;
    tick();
    status(0, "mid_rst", 5'd0, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    // Mispredict counter saturation, then clear colliding with a trigger
    do_reset();
    drive(1'b1, 32'h300, 1'b1, 32'h2FC, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (i == 65534) check("sat_fffe", 64'(ifa.mispredict_count), 64'hFFFE);
    end
    check("sat_ffff", 64'(ifa.mispredict_count), 64'hFFFF);
    check("sat_frozen", 64'(ifa.frozen), 64'd0);
    drive(1'b1, 32'h40, 1'b1, 32'h3C, 1'b1, 32'h40, 1'b1, 1'b0);
    tick();
    status(0, "clr_trig_a", 5'd0, 1'b0, 1'b0, 16'd0);
    status(1, "clr_trig_b", 5'd0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check("post_clr_cnt_a", 64'(ifa.entry_count), 64'd1);
    check("post_clr_cnt_b", 64'(ifb.entry_count), 64'd1);
    check("post_clr_frz_b", 64'(ifb.frozen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
